// File: rtl/lot_ticket_tx.sv
// Transmitter for the lottery digit interface: serializes a BCD ticket into
// num/insere strobes and closes every ticket with a one-cycle fim_jogo pulse.
module lot_ticket_tx #(
  parameter int NDIG      = 5,
  parameter int GAP       = 1,
  parameter int FIM_DELAY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [4*NDIG-1:0] ticket,
  input  logic              abort,
  output logic              ready,
  output logic [3:0]        num,
  output logic              insere,
  output logic              fim_jogo,
  output logic              err,
  output logic [7:0]        sent_cnt
);

  localparam int TW   = 4 * NDIG;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int CMAX = (GAP > FIM_DELAY) ? GAP : FIM_DELAY;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_TAIL,
    S_FIM
  } state_t;

  state_t          r_state;
  logic [TW-1:0]   r_shift;
  logic [IW-1:0]   r_idx;
  logic [CW-1:0]   r_cnt;

  state_t          w_state_n;
  logic [TW-1:0]   w_shift_n;
  logic [IW-1:0]   w_idx_n;
  logic [CW-1:0]   w_cnt_n;
  logic [3:0]      w_num_n;
  logic            w_err_n;
  logic            w_adv;
  logic            w_done;
  logic            w_ticket_ok;

  always_comb begin
    w_ticket_ok = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (ticket[4*i +: 4] > 4'd9) w_ticket_ok = 1'b0;
    end
  end

  // NOTE: every signal driven here gets a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_state_n = r_state;
    w_shift_n = r_shift;
    w_idx_n   = r_idx;
    w_cnt_n   = r_cnt;
    w_num_n   = 4'd0;
    w_err_n   = err;
    w_adv     = 1'b0;
    w_done    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_ticket_ok) begin
            w_state_n = S_SEND;
            w_num_n   = ticket[TW-1 -: 4];
            w_shift_n = ticket << 4;
            w_idx_n   = '0;
            w_err_n   = 1'b0;
          end else begin
            w_err_n = 1'b1;
          end
        end
      end
      S_SEND: begin
        if (abort) begin
          w_state_n = S_FIM;
        end else if (r_idx == IW'(NDIG - 1)) begin
          if (FIM_DELAY > 0) begin
            w_state_n = S_TAIL;
            w_cnt_n   = '0;
          end else begin
            w_state_n = S_FIM;
            w_done    = 1'b1;
          end
        end else if (GAP > 0) begin
          w_state_n = S_GAP;
          w_cnt_n   = '0;
        end else begin
          w_adv = 1'b1;
        end
      end
      S_GAP: begin
        if (abort)                          w_state_n = S_FIM;
        else if (r_cnt == CW'(GAP - 1))     w_adv     = 1'b1;
        else                                w_cnt_n   = r_cnt + CW'(1);
      end
      S_TAIL: begin
        if (abort) begin
          w_state_n = S_FIM;
        end else if (r_cnt == CW'(FIM_DELAY - 1)) begin
          w_state_n = S_FIM;
          w_done    = 1'b1;
        end else begin
          w_cnt_n = r_cnt + CW'(1);
        end
      end
      S_FIM:   w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase

    // Next digit comes off the top of the shift register.
    if (w_adv) begin
      w_state_n = S_SEND;
      w_num_n   = r_shift[TW-1 -: 4];
      w_shift_n = r_shift << 4;
      w_idx_n   = r_idx + IW'(1);
    end
  end

  // Outputs are registered from the next state so they line up with it.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      ready    <= 1'b1;
      num      <= 4'd0;
      insere   <= 1'b0;
      fim_jogo <= 1'b0;
      err      <= 1'b0;
      sent_cnt <= 8'd0;
    end else begin
      r_state  <= w_state_n;
      r_shift  <= w_shift_n;
      r_idx    <= w_idx_n;
      r_cnt    <= w_cnt_n;
      ready    <= (w_state_n == S_IDLE);
      num      <= w_num_n;
      insere   <= (w_state_n == S_SEND);
      fim_jogo <= (w_state_n == S_FIM);
      err      <= w_err_n;
      if (w_done) sent_cnt <= sent_cnt + 8'd1;
    end
  end

endmodule
